jpeg_block_sequencer: RTL

Control FSM that sequences the three-channel (Y/Cb/Cr) JPEG encoder datapath one 8x8 block at a time. It accepts a raster RGB pixel stream through a valid/ready handshake and times `input_1pix_enable` to match the RGB-to-YCbCr conversion latency. It then issues the block-level strobes `input_enable`, `dct_enable`, `dct_end_enable`, `zigzag_input_enable` and `Huffman_start`, and waits for all three Huffman channels to finish before loading the next block. It sits directly above the encoder top level and replaces the manual testbench control of those strobes.

---
 rtl/jpeg_block_sequencer_if.sv | 22 ++
 rtl/jpeg_block_sequencer.sv | 82 ++++++++
 2 files changed

// File: rtl/jpeg_block_sequencer_if.sv
// jpeg_block_sequencer_if: pixel handshake, Huffman completion and block strobes between sequencer and encoder
interface jpeg_block_sequencer_if;
  logic pix_valid;
  logic pix_ready;
  logic [2:0] huff_done;
  logic input_1pix_enable;
  logic input_enable;
  logic dct_enable;
  logic dct_end_enable;
  logic zigzag_input_enable;
  logic Huffman_start;
  modport master (
    input pix_valid, huff_done,
    output pix_ready, input_1pix_enable, input_enable, dct_enable, dct_end_enable,
      zigzag_input_enable, Huffman_start
  );
  modport slave (
    output pix_valid, huff_done,
    input pix_ready, input_1pix_enable, input_enable, dct_enable, dct_end_enable,
      zigzag_input_enable, Huffman_start
  );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// jpeg_block_sequencer: sequences the Y/Cb/Cr JPEG encoder datapath one 8x8 block at a time
module jpeg_block_sequencer #(
  parameter int CONV_LATENCY = 1,
  parameter int DCT_CYCLES = 8,
  parameter int HUFF_TIMEOUT = 1023,
  parameter int BLOCKS_PER_FRAME = 1
) (
  input logic clock,
  input logic reset,
  input logic start,
  jpeg_block_sequencer_if.master enc,
  output logic busy,
  output logic block_done,
  output logic frame_done,
  output logic [15:0] block_count,
  output logic timeout_err
);
  typedef enum logic [3:0] {IDLE, LOAD, FLUSH, LATCH, DCT, DCT_END, ZIGZAG, HSTART, HWAIT} state_t;
  localparam int SRW = CONV_LATENCY > 0 ? CONV_LATENCY : 1;
  state_t state, nxt;
  logic [5:0] pix_cnt;
  logic [15:0] tmr;
  logic [2:0] hflags;
  logic [SRW-1:0] sr;
  logic accept, all_done, timed_out, hw_exit, last_block;
  assign accept = enc.pix_valid & enc.pix_ready;
  assign all_done = &(hflags | enc.huff_done);
  assign timed_out = tmr == 16'(HUFF_TIMEOUT);
  assign hw_exit = state == HWAIT && (all_done || timed_out);
  assign last_block = block_count + 16'd1 == 16'(BLOCKS_PER_FRAME);
  assign busy = state != IDLE;
  assign enc.pix_ready = state == LOAD;
  assign enc.input_enable = state == LATCH;
  assign enc.dct_enable = state == DCT;
  assign enc.dct_end_enable = state == DCT_END;
  assign enc.zigzag_input_enable = state == ZIGZAG;
  assign enc.Huffman_start = state == HSTART;
  assign enc.input_1pix_enable = CONV_LATENCY == 0 ? accept : sr[SRW-1];
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? LOAD : IDLE;
      LOAD: if (accept && pix_cnt == 6'd63) nxt = CONV_LATENCY == 0 ? LATCH : FLUSH;
      FLUSH: if (tmr == 16'd0) nxt = LATCH;
      LATCH: nxt = DCT;
      DCT: if (tmr == 16'd0) nxt = DCT_END;
      DCT_END: nxt = ZIGZAG;
      ZIGZAG: nxt = HSTART;
      HSTART: nxt = HWAIT;
      HWAIT: if (hw_exit) nxt = last_block ? IDLE : LOAD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) state <= reset ? IDLE : nxt;
  // tmr is reused: FLUSH/DCT count down to 0, HWAIT counts its own cycles up from 1
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_cnt <= '0;
      tmr <= '0;
      hflags <= '0;
      sr <= '0;
      block_count <= '0;
      timeout_err <= 1'b0;
      block_done <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pix_cnt <= accept ? pix_cnt + 6'd1 : pix_cnt;
      sr <= SRW'({sr, accept});
      tmr <= state == LOAD ? 16'(CONV_LATENCY - 1) :
             state == LATCH ? 16'(DCT_CYCLES - 1) :
             state == HSTART ? 16'd1 :
             (state == FLUSH || state == DCT) ? tmr - 16'd1 :
             state == HWAIT ? tmr + 16'd1 : tmr;
      hflags <= state == ZIGZAG ? 3'b000 :
                (state == HSTART || state == HWAIT) ? hflags | enc.huff_done : hflags;
      block_count <= (state == IDLE && start) ? 16'd0 : hw_exit ? block_count + 16'd1 : block_count;
      timeout_err <= (state == IDLE && start) ? 1'b0 : (hw_exit && !all_done) ? 1'b1 : timeout_err;
      block_done <= hw_exit;
      frame_done <= hw_exit && last_block;
    end
  end
endmodule
